// File: rtl/instruction_fetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue of (instr, pc) pairs, valid/ready to decode.
// Optional combinational response bypass into an empty queue: define IFQ_BYPASS_EN.
module instruction_fetch_queue #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    PC_STEP     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_pc,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [ADDR_WIDTH-1:0]  pc4_out
);

  localparam int                    PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                    CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]           DEPTH_L = (CW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic                   inflight;
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;

  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  target;
  logic [CW:0]            occupancy;
  logic                   head_valid;
  logic                   resp_ok;
  logic                   bypass;
  logic                   enq;
  logic                   deq;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic [ADDR_WIDTH-1:0]  head_pc;

  always_comb begin
    redirect  = branch_taken | jump;
    target    = branch_taken ? branch_pc : jump_pc;
    // The in-flight word counts against capacity so its response always has a slot.
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req  = reset && !redirect && (occupancy < DEPTH_L);
    imem_addr = fetch_pc;

    head_valid = (count != '0);
    resp_ok    = imem_rvalid && inflight && !redirect;
`ifdef IFQ_BYPASS_EN
    bypass     = reset && !head_valid && resp_ok && instr_ready;
`else
    bypass     = 1'b0;
`endif
    enq         = resp_ok && !bypass;
    instr_valid = reset && !redirect && (head_valid || bypass);
    deq         = instr_valid && instr_ready && head_valid;

    head_instr = head_valid ? instr_mem[rd_ptr] : '0;
    head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
    instr_out  = bypass ? imem_rdata  : head_instr;
    pc_out     = bypass ? inflight_pc : head_pc;
    pc4_out    = (head_valid || bypass) ? (pc_out + STEP) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (redirect) begin
      // Flush wins over any response landing this cycle.
      fetch_pc <= target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (imem_req) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + STEP;
      end else begin
        inflight <= 1'b0;
      end

      if (enq) begin
        instr_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]    <= inflight_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end

      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
